phy_rx_link_ctrl: RTL and testbench

Link-bring-up and supervision controller for the two-lane receive PHY. It resets the serial-to-parallel lanes and waits until both report sync via active_ser_par_1/2. It then declares the link up and gates valid_output to the downstream logic. On sync loss it runs a bounded recovery window before forcing a full retrain. It also keeps word and error statistics. Runs in the clk_f domain, beside phy_rx, between the PHY and the link layer.

---
 rtl/phy_rx_link_ctrl.sv | 138 +++++++++++++
 tb/tb_phy_rx_link_ctrl.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/phy_rx_link_ctrl.sv
// Link bring-up and supervision controller for the two-lane receive PHY.
// Ports: clk_f/reset (sync, active-high); active_ser_par_1/2 lane sync;
//   valid_output word strobe; retrain_req forced retrain; lane_reset_1/2
//   deserializer resets; link_up, link_state; valid_gated; word_count
//   (wrapping) and error_count (saturating) statistics.
module phy_rx_link_ctrl #(
    parameter int STABLE_CYCLES  = 4,
    parameter int TIMEOUT_CYCLES = 64,
    parameter int RECOVER_CYCLES = 8,
    parameter int RST_CYCLES     = 2
) (
    input  logic        clk_f,
    input  logic        reset,
    input  logic        active_ser_par_1,
    input  logic        active_ser_par_2,
    input  logic        valid_output,
    input  logic        retrain_req,
    output logic        lane_reset_1,
    output logic        lane_reset_2,
    output logic        link_up,
    output logic [1:0]  link_state,
    output logic        valid_gated,
    output logic [15:0] word_count,
    output logic [7:0]  error_count
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        TRAIN   = 2'd1,
        UP      = 2'd2,
        RECOVER = 2'd3
    } state_t;

    localparam int CW = 16;
    localparam logic [CW-1:0] RST_LAST     = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);
    localparam logic [CW-1:0] RECOVER_LAST = CW'(RECOVER_CYCLES - 1);
    localparam logic [CW-1:0] STABLE_LAST  = CW'(STABLE_CYCLES - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [CW-1:0] stable_q, stable_d;
    logic [15:0]   word_q, word_d;
    logic [7:0]    err_q, err_d;
    logic          lane_rst_q, lane_rst_d;
    logic          link_up_q, link_up_d;
    logic          both;
    logic          err_inc;

    assign both = active_ser_par_1 & active_ser_par_2;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        stable_d = stable_q;
        word_d   = word_q;
        err_inc  = 1'b0;

        // The drop cycle in UP still counts its word.
        if (state_q == UP && valid_output) begin
            word_d = word_q + 16'd1;
        end

        if (retrain_req && state_q != IDLE) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (cnt_q == RST_LAST) state_d = TRAIN;
                    else cnt_d = cnt_q + 1'b1;
                end
                TRAIN: begin
                    // UP wins over a timeout on the same edge.
                    if (both && stable_q == STABLE_LAST) begin
                        state_d = UP;
                    end else if (cnt_q == TIMEOUT_LAST) begin
                        state_d = IDLE;
                        err_inc = 1'b1;
                    end else begin
                        cnt_d    = cnt_q + 1'b1;
                        stable_d = both ? stable_q + 1'b1 : '0;
                    end
                end
                UP: begin
                    if (!both) begin
                        state_d = RECOVER;
                        err_inc = 1'b1;
                    end
                end
                RECOVER: begin
                    if (both) state_d = UP;
                    else if (cnt_q == RECOVER_LAST) state_d = IDLE;
                    else cnt_d = cnt_q + 1'b1;
                end
            endcase
        end

        // Shared phase counter restarts on every state entry.
        if (state_d != state_q) begin
            cnt_d    = '0;
            stable_d = '0;
        end

        err_d = (err_inc && err_q != 8'hFF) ? err_q + 8'd1 : err_q;

        lane_rst_d = (state_d == IDLE);
        link_up_d  = (state_d == UP);
    end

    always_ff @(posedge clk_f) begin
        if (reset) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            stable_q   <= '0;
            word_q     <= '0;
            err_q      <= '0;
            lane_rst_q <= 1'b1;
            link_up_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            stable_q   <= stable_d;
            word_q     <= word_d;
            err_q      <= err_d;
            lane_rst_q <= lane_rst_d;
            link_up_q  <= link_up_d;
        end
    end

    assign lane_reset_1 = lane_rst_q;
    assign lane_reset_2 = lane_rst_q;
    assign link_up      = link_up_q;
    assign link_state   = state_q;
    assign valid_gated  = valid_output & link_up_q;
    assign word_count   = word_q;
    assign error_count  = err_q;

endmodule

// File: tb/tb_phy_rx_link_ctrl.sv
// Self-checking bench for phy_rx_link_ctrl: vector table, directed corner
// sequences and randomized traffic against a behavioural reference model.
module tb_phy_rx_link_ctrl;

    logic        clk_f;
    logic        reset;
    logic        active_ser_par_1;
    logic        active_ser_par_2;
    logic        valid_output;
    logic        retrain_req;
    logic        lane_reset_1;
    logic        lane_reset_2;
    logic        link_up;
    logic [1:0]  link_state;
    logic        valid_gated;
    logic [15:0] word_count;
    logic [7:0]  error_count;

    phy_rx_link_ctrl dut (
        .clk_f            (clk_f),
        .reset            (reset),
        .active_ser_par_1 (active_ser_par_1),
        .active_ser_par_2 (active_ser_par_2),
        .valid_output     (valid_output),
        .retrain_req      (retrain_req),
        .lane_reset_1     (lane_reset_1),
        .lane_reset_2     (lane_reset_2),
        .link_up          (link_up),
        .link_state       (link_state),
        .valid_gated      (valid_gated),
        .word_count       (word_count),
        .error_count      (error_count)
    );

    initial clk_f = 1'b0;
    always #5 clk_f = ~clk_f;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: mode names follow the link_state encoding.
    localparam int M_IDLE = 0, M_TRAIN = 1, M_UP = 2, M_REC = 3;
    int m_mode   = M_IDLE;
    int m_phase  = 0;
    int m_run    = 0;
    int m_words  = 0;
    int m_errs   = 0;

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic void enter(input int mode);
        m_mode  = mode;
        m_phase = 0;
        m_run   = 0;
    endfunction

    function automatic void model(input bit rst, input bit a1, input bit a2,
                                  input bit v, input bit rt);
        bit both;
        both = a1 && a2;
        if (rst) begin
            enter(M_IDLE);
            m_words = 0;
            m_errs  = 0;
            return;
        end
        if (m_mode == M_UP && v) m_words = (m_words + 1) % 65536;
        if (rt && m_mode != M_IDLE) begin
            enter(M_IDLE);
            return;
        end
        case (m_mode)
            M_IDLE:
                if (m_phase + 1 >= 2) enter(M_TRAIN);
                else m_phase++;
            M_TRAIN:
                if (both && m_run + 1 >= 4) enter(M_UP);
                else if (m_phase + 1 >= 64) begin
                    if (m_errs < 255) m_errs++;
                    enter(M_IDLE);
                end else begin
                    m_phase++;
                    m_run = both ? m_run + 1 : 0;
                end
            M_UP:
                if (!both) begin
                    if (m_errs < 255) m_errs++;
                    enter(M_REC);
                end
            default:
                if (both) enter(M_UP);
                else if (m_phase + 1 >= 8) enter(M_IDLE);
                else m_phase++;
        endcase
    endfunction

    task automatic step(input bit rst, input bit a1, input bit a2,
                        input bit v, input bit rt);
        reset            = rst;
        active_ser_par_1 = a1;
        active_ser_par_2 = a2;
        valid_output     = v;
        retrain_req      = rt;
        #1;
        check("valid_gated", int'(valid_gated), int'(v && m_mode == M_UP));
        @(posedge clk_f);
        model(rst, a1, a2, v, rt);
        #1;
        check("link_state", int'(link_state), m_mode);
        check("link_up", int'(link_up), int'(m_mode == M_UP));
        check("lane_reset_1", int'(lane_reset_1), int'(m_mode == M_IDLE));
        check("lane_reset_2", int'(lane_reset_2), int'(m_mode == M_IDLE));
        check("word_count", int'(word_count), m_words);
        check("error_count", int'(error_count), m_errs);
    endtask

    task automatic bring_up();
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++) step(0, 1, 1, 0, 0);
        check("bring_up", int'(link_up), 1);
    endtask

    typedef struct {
        bit rst, a1, a2, v, rt;
        int st, lu, lr, wc, ec;
    } vec_t;

    vec_t tbl[$];

    initial begin
        int n;
        int cnt;
        bit hi;
        reset = 1'b1;
        active_ser_par_1 = 1'b0;
        active_ser_par_2 = 1'b0;
        valid_output = 1'b0;
        retrain_req = 1'b0;

        // Bring-up, words in UP, sync loss, recovery, retrain.
        tbl.push_back('{1,0,0,0,0, 0,0,1,0,0});
        tbl.push_back('{0,1,1,0,0, 0,0,1,0,0});
        tbl.push_back('{0,1,1,0,0, 1,0,0,0,0});
        tbl.push_back('{0,1,1,1,0, 1,0,0,0,0});
        tbl.push_back('{0,1,1,0,0, 1,0,0,0,0});
        tbl.push_back('{0,1,1,0,0, 1,0,0,0,0});
        tbl.push_back('{0,1,1,0,0, 2,1,0,0,0});
        tbl.push_back('{0,1,1,1,0, 2,1,0,1,0});
        tbl.push_back('{0,1,1,1,0, 2,1,0,2,0});
        tbl.push_back('{0,1,0,1,0, 3,0,0,3,1});
        tbl.push_back('{0,1,1,1,0, 2,1,0,3,1});
        tbl.push_back('{0,1,1,0,1, 0,0,1,3,1});
        tbl.push_back('{0,0,0,0,0, 0,0,1,3,1});
        tbl.push_back('{0,0,0,0,0, 1,0,0,3,1});
        // Stability run broken by a single 0 in TRAIN.
        tbl.push_back('{1,0,0,0,0, 0,0,1,0,0});
        tbl.push_back('{0,0,0,0,0, 0,0,1,0,0});
        tbl.push_back('{0,0,0,0,0, 1,0,0,0,0});
        tbl.push_back('{0,1,1,0,0, 1,0,0,0,0});
        tbl.push_back('{0,1,1,0,0, 1,0,0,0,0});
        tbl.push_back('{0,1,1,0,0, 1,0,0,0,0});
        tbl.push_back('{0,0,1,0,0, 1,0,0,0,0});
        tbl.push_back('{0,1,1,0,0, 1,0,0,0,0});
        tbl.push_back('{0,1,1,0,0, 1,0,0,0,0});
        tbl.push_back('{0,1,1,0,0, 1,0,0,0,0});
        tbl.push_back('{0,1,1,0,0, 2,1,0,0,0});

        foreach (tbl[i]) begin
            step(tbl[i].rst, tbl[i].a1, tbl[i].a2, tbl[i].v, tbl[i].rt);
            check($sformatf("tbl%0d_state", i), int'(link_state), tbl[i].st);
            check($sformatf("tbl%0d_up", i), int'(link_up), tbl[i].lu);
            check($sformatf("tbl%0d_lrst", i), int'(lane_reset_1), tbl[i].lr);
            check($sformatf("tbl%0d_words", i), int'(word_count), tbl[i].wc);
            check($sformatf("tbl%0d_errs", i), int'(error_count), tbl[i].ec);
        end

        // Training timeouts: 64 TRAIN cycles each, one error per timeout.
        step(1, 0, 0, 0, 0);
        for (int r = 0; r < 3; r++) begin
            step(0, 0, 0, 0, 0);
            step(0, 0, 0, 0, 0);
            check("timeout_train_entry", int'(link_state), 1);
            n = 0;
            while (link_state == 2'd1 && n < 200) begin
                step(0, 0, 0, 0, 0);
                n++;
            end
            check("timeout_train_len", n, 64);
            check("timeout_errs", int'(error_count), r + 1);
        end

        // Error counter saturation through repeated sync losses.
        bring_up();
        for (int i = 0; i < 300; i++) begin
            step(0, 1, 0, 0, 0);
            step(0, 1, 1, 0, 0);
        end
        check("err_saturate", int'(error_count), 255);

        // Word counter wrap.
        bring_up();
        for (int i = 0; i < 70000; i++) step(0, 1, 1, 1, 0);
        check("word_wrap", int'(word_count), 4464);
        step(0, 1, 0, 0, 0);
        step(0, 1, 0, 1, 0);
        check("gated_in_recover", int'(valid_gated), 0);

        // Short drop recovers; long drop falls back to IDLE.
        bring_up();
        for (int i = 0; i < 3; i++) step(0, 1, 0, 0, 0);
        step(0, 1, 1, 0, 0);
        check("short_drop_up", int'(link_state), 2);
        check("short_drop_errs", int'(error_count), 1);
        cnt = 0;
        for (int i = 0; i < 9; i++) begin
            step(0, 1, 0, 0, 0);
            if (link_state == 2'd3) cnt++;
        end
        check("long_drop_rec_cycles", cnt, 8);
        check("long_drop_idle", int'(link_state), 0);
        check("long_drop_errs", int'(error_count), 2);
        cnt = 1;
        n = 0;
        while (lane_reset_1 && n < 10) begin
            step(0, 1, 1, 0, 0);
            if (lane_reset_1) cnt++;
            n++;
        end
        check("long_drop_lrst_cycles", cnt, 2);

        // Retrain on the same cycle a lane drops.
        bring_up();
        step(0, 1, 0, 0, 1);
        check("retrain_drop_state", int'(link_state), 0);
        check("retrain_drop_errs", int'(error_count), 0);

        // Reset while in RECOVER.
        bring_up();
        for (int i = 0; i < 3; i++) step(0, 1, 1, 1, 0);
        step(0, 1, 0, 1, 0);
        step(0, 1, 0, 0, 0);
        check("pre_reset_rec", int'(link_state), 3);
        step(1, 1, 0, 0, 0);
        check("reset_rec_state", int'(link_state), 0);
        check("reset_rec_words", int'(word_count), 0);
        check("reset_rec_errs", int'(error_count), 0);
        check("reset_rec_lrst", int'(lane_reset_2), 1);

        // Randomized traffic with alternating lane quality.
        hi = 1'b1;
        for (int i = 0; i < 4000; i++) begin
            bit a1, a2;
            if (i % 250 == 0) hi = ~hi;
            if (hi) begin
                a1 = ($urandom % 12) != 0;
                a2 = ($urandom % 12) != 0;
            end else begin
                a1 = ($urandom % 3) == 0;
                a2 = ($urandom % 3) == 0;
            end
            step(($urandom % 700) == 0, a1, a2, 1'($urandom % 2),
                 ($urandom % 150) == 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
